frame_capture_writer: RTL and testbench

//  Sink end of the pixel stream: captures one frame of processed pixels (valid-qualified, no backpressure)

---
 rtl/canny_pkg.sv | 22 ++
 rtl/frame_buffer_ram.sv | 37 +++
 rtl/frame_capture_writer.sv | 166 ++++++++++++++++
 tb/tb_frame_capture_writer.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/canny_pkg.sv
// Shared defaults, state type and sizing helpers for the canny pixel-pipeline blocks.
package canny_pkg;

    localparam int PIX_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        FCW_IDLE,
        FCW_CAPTURE,
        FCW_DRAIN,
        FCW_DONE
    } fcw_state_t;

    // Counter width must be able to hold FRAME_PX itself, not just FRAME_PX-1.
    function automatic int fcw_cnt_w(input int frame_px);
        return $clog2(frame_px) + 1;
    endfunction

    function automatic int fcw_addr_w(input int frame_px);
        return (frame_px > 1) ? $clog2(frame_px) : 1;
    endfunction

endpackage

// File: rtl/frame_buffer_ram.sv
// Simple dual-port frame store: one write port, one read port with a single registered read stage.
module frame_buffer_ram #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdData;

    // Storage has no reset so it can map onto block RAM; contents survive a reset untouched.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdData <= '0;
        end else if (i_rd_en) begin
            r_rdData <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rdData;

endmodule

// File: rtl/frame_capture_writer.sv
// Captures one frame of streamed pixels into on-chip RAM, then replays it over a ready/valid port.
// Optional checksum output is enabled by defining FRAME_WRITER_CHECKSUM_EN.
module frame_capture_writer
    import canny_pkg::*;
#(
    parameter int IMG_W    = 512,
    parameter int IMG_H    = 512,
    parameter int PIX_W    = PIX_W_DEFAULT,
    parameter int FRAME_PX = IMG_W * IMG_H
) (
    input  logic                       clk,
    input  logic                       rstN,
    input  logic                       frame_start,
    input  logic [PIX_W-1:0]           pixel_in,
    input  logic                       pixel_in_valid,
    output logic [PIX_W-1:0]           rd_data,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic                       busy,
    output logic                       frame_done,
    output logic                       overflow,
`ifdef FRAME_WRITER_CHECKSUM_EN
    output logic [15:0]                checksum,
`endif
    output logic [$clog2(FRAME_PX):0]  px_count
);

    localparam int CNT_W  = fcw_cnt_w(FRAME_PX);
    localparam int ADDR_W = fcw_addr_w(FRAME_PX);
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(FRAME_PX - 1);
    localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_PX);

    fcw_state_t       r_state;
    logic [CNT_W-1:0] r_pxCount;
    logic [CNT_W-1:0] r_rdAddr;
    logic             r_overflow;
    logic             r_qValid;
    logic             r_skidValid;
    logic [PIX_W-1:0] r_skid;

    logic             w_wrEn;
    logic             w_rdEn;
    logic             w_fire;
    logic             w_lastAccept;
    logic             w_pixelStray;
    logic [PIX_W-1:0] w_ramQ;

    // Write address is the running pixel count; it never reaches FRAME_PX while capturing.
    assign w_wrEn = (r_state == FCW_CAPTURE) && pixel_in_valid && !frame_start;

    // At most one byte is ever held (RAM output or skid), so a read may be issued
    // whenever that byte leaves this cycle or nothing is held.
    assign w_fire       = rd_valid && rd_ready;
    assign w_rdEn       = (r_state == FCW_DRAIN) && !frame_start &&
                          (r_rdAddr < FRAME_CNT) && (!rd_valid || rd_ready);
    assign w_lastAccept = (r_state == FCW_DRAIN) && w_fire && (r_rdAddr == FRAME_CNT);
    assign w_pixelStray = pixel_in_valid && !frame_start &&
                          ((r_state == FCW_DRAIN) || (r_state == FCW_DONE));

    frame_buffer_ram #(
        .DEPTH  (FRAME_PX),
        .DATA_W (PIX_W),
        .ADDR_W (ADDR_W)
    ) u_frame_buffer_ram (
        .i_clk     (clk),
        .i_rst_n   (rstN),
        .i_wr_en   (w_wrEn),
        .i_wr_addr (r_pxCount[ADDR_W-1:0]),
        .i_wr_data (pixel_in),
        .i_rd_en   (w_rdEn),
        .i_rd_addr (r_rdAddr[ADDR_W-1:0]),
        .o_rd_data (w_ramQ)
    );

    // frame_start has priority in every state: it both arms a fresh capture and aborts one in flight.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state    <= FCW_IDLE;
            r_pxCount  <= '0;
            r_rdAddr   <= '0;
            r_overflow <= 1'b0;
        end else if (frame_start) begin
            r_state    <= FCW_CAPTURE;
            r_pxCount  <= '0;
            r_rdAddr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_pixelStray) begin
                r_overflow <= 1'b1;
            end
            case (r_state)
                FCW_IDLE: begin
                    r_state <= FCW_IDLE;
                end
                FCW_CAPTURE: begin
                    if (w_wrEn) begin
                        r_pxCount <= r_pxCount + 1'b1;
                        if (r_pxCount == LAST_IDX) begin
                            r_state <= FCW_DRAIN;
                        end
                    end
                end
                FCW_DRAIN: begin
                    if (w_rdEn) begin
                        r_rdAddr <= r_rdAddr + 1'b1;
                    end
                    if (w_lastAccept) begin
                        r_state <= FCW_DONE;
                    end
                end
                FCW_DONE: begin
                    r_state <= FCW_IDLE;
                end
                default: begin
                    r_state <= FCW_IDLE;
                end
            endcase
        end
    end

    // A RAM byte that is not taken on its first cycle parks in the skid so the RAM port is free again.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_qValid    <= 1'b0;
            r_skidValid <= 1'b0;
            r_skid      <= '0;
        end else if (frame_start) begin
            r_qValid    <= 1'b0;
            r_skidValid <= 1'b0;
        end else begin
            r_qValid <= w_rdEn;
            if (r_skidValid) begin
                if (w_fire) begin
                    r_skidValid <= 1'b0;
                end
            end else if (r_qValid && !w_fire) begin
                r_skid      <= w_ramQ;
                r_skidValid <= 1'b1;
            end
        end
    end

    assign rd_valid   = r_qValid || r_skidValid;
    assign rd_data    = r_skidValid ? r_skid : (r_qValid ? w_ramQ : '0);
    assign busy       = (r_state != FCW_IDLE);
    assign frame_done = (r_state == FCW_DONE);
    assign overflow   = r_overflow;
    assign px_count   = r_pxCount;

`ifdef FRAME_WRITER_CHECKSUM_EN
    logic [15:0] r_checksum;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_checksum <= '0;
        end else if (frame_start) begin
            r_checksum <= '0;
        end else if (w_wrEn) begin
            r_checksum <= r_checksum + 16'(pixel_in);
        end
    end

    assign checksum = r_checksum;
`endif

endmodule

// File: tb/tb_frame_capture_writer.sv
// Randomised self-checking bench for frame_capture_writer on a 4x4 frame, with a queue-based
// model of which pixels end up in the frame; also exercises FRAME_WRITER_CHECKSUM_EN when defined.
module tb_frame_capture_writer;

    localparam int IMG_W    = 4;
    localparam int IMG_H    = 4;
    localparam int FRAME_PX = IMG_W * IMG_H;
    localparam int PIX_W    = 8;
    localparam int CNT_W    = $clog2(FRAME_PX) + 1;

    logic             clk = 1'b0;
    logic             rstN = 1'b0;
    logic             frame_start = 1'b0;
    logic [PIX_W-1:0] pixel_in = '0;
    logic             pixel_in_valid = 1'b0;
    logic             rd_ready = 1'b0;
    logic [PIX_W-1:0] rd_data;
    logic             rd_valid;
    logic             busy;
    logic             frame_done;
    logic             overflow;
    logic [CNT_W-1:0] px_count;
`ifdef FRAME_WRITER_CHECKSUM_EN
    logic [15:0]      checksum;
`endif

    frame_capture_writer #(
        .IMG_W    (IMG_W),
        .IMG_H    (IMG_H),
        .PIX_W    (PIX_W),
        .FRAME_PX (FRAME_PX)
    ) dut (
        .clk            (clk),
        .rstN           (rstN),
        .frame_start    (frame_start),
        .pixel_in       (pixel_in),
        .pixel_in_valid (pixel_in_valid),
        .rd_data        (rd_data),
        .rd_valid       (rd_valid),
        .rd_ready       (rd_ready),
        .busy           (busy),
        .frame_done     (frame_done),
        .overflow       (overflow),
`ifdef FRAME_WRITER_CHECKSUM_EN
        .checksum       (checksum),
`endif
        .px_count       (px_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model: pixels that should be in the frame, in capture order, plus the expected sticky overflow.
    logic [PIX_W-1:0] expQ[$];
    int               expCount;
    bit               expOverflow;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input bit withPixel);
        frame_start    = 1'b1;
        pixel_in_valid = withPixel;
        pixel_in       = 8'h55;
        step();
        frame_start    = 1'b0;
        pixel_in_valid = 1'b0;
        expQ.delete();
        expCount    = 0;
        expOverflow = 1'b0;
        checks++;
        if (busy !== 1'b1 || px_count !== '0 || overflow !== 1'b0 || rd_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL start_frame: got busy=%b px=%0d ovf=%b rv=%b required 1 0 0 0",
                     busy, px_count, overflow, rd_valid);
        end
    endtask

    task automatic push_pixel(input logic [PIX_W-1:0] v, input int maxGap);
        repeat ($urandom_range(maxGap, 0)) step();
        pixel_in       = v;
        pixel_in_valid = 1'b1;
        step();
        pixel_in_valid = 1'b0;
        if (expCount < FRAME_PX) begin
            expQ.push_back(v);
            expCount++;
        end
    endtask

    task automatic check_captured(input string name);
        int sum = 0;
        checks++;
        if (px_count !== CNT_W'(expCount)) begin
            failures++;
            $display("[TB] FAIL %s_px_count: got %0d required %0d", name, px_count, expCount);
        end
`ifdef FRAME_WRITER_CHECKSUM_EN
        foreach (expQ[i]) sum += int'(expQ[i]);
        checks++;
        if (checksum !== 16'(sum)) begin
            failures++;
            $display("[TB] FAIL %s_checksum: got %0h required %0h", name, checksum, 16'(sum));
        end
`else
        sum = 0;
`endif
    endtask

    task automatic drain_frame(input string name, input int readyPct, input int ovfPct, input bit strict);
        int               budget = 0;
        bit               held = 1'b0;
        bit               started = 1'b0;
        logic [PIX_W-1:0] heldData = '0;
        while (expQ.size() > 0 && budget < 1000) begin
            if (started && strict && rd_valid !== 1'b1) begin
                checks++;
                failures++;
                $display("[TB] FAIL %s_gap: got rd_valid=%b required 1", name, rd_valid);
            end
            if (held) begin
                checks++;
                if (rd_valid !== 1'b1 || rd_data !== heldData) begin
                    failures++;
                    $display("[TB] FAIL %s_hold: got %b/%0h required 1/%0h", name, rd_valid, rd_data, heldData);
                end
            end
            pixel_in_valid = ($urandom_range(99, 0) < ovfPct);
            pixel_in       = 8'hAA;
            if (pixel_in_valid) expOverflow = 1'b1;
            rd_ready = ($urandom_range(99, 0) < readyPct);
            if (rd_valid === 1'b1) begin
                started = 1'b1;
                if (rd_ready) begin
                    checks++;
                    if (rd_data !== expQ[0]) begin
                        failures++;
                        $display("[TB] FAIL %s_data: got %0h required %0h", name, rd_data, expQ[0]);
                    end
                    void'(expQ.pop_front());
                    held = 1'b0;
                end else begin
                    held     = 1'b1;
                    heldData = rd_data;
                end
            end
            step();
            budget++;
        end
        pixel_in_valid = 1'b0;
        rd_ready       = 1'b0;
        if (budget >= 1000) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s_timeout: got %0d bytes left required 0", name, expQ.size());
        end
        checks++;
        if (frame_done !== 1'b1 || rd_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL %s_done: got done=%b rv=%b required 1 0", name, frame_done, rd_valid);
        end
        checks++;
        if (overflow !== expOverflow) begin
            failures++;
            $display("[TB] FAIL %s_overflow: got %b required %b", name, overflow, expOverflow);
        end
        step();
        checks++;
        if (frame_done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL %s_idle: got done=%b busy=%b required 0 0", name, frame_done, busy);
        end
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        #3;
        checks++;
        if (rd_valid !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0 || overflow !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_flags: got %b%b%b%b required 0000", rd_valid, busy, frame_done, overflow);
        end
        checks++;
        if (rd_data !== '0 || px_count !== '0) begin
            failures++;
            $display("[TB] FAIL reset_values: got data=%0h px=%0d required 0 0", rd_data, px_count);
        end
        @(negedge clk);
        rstN = 1'b1;
        step();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_release: got busy=%b required 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        start_frame(1'b0);
        rd_ready = 1'b1;
        for (int i = 0; i < FRAME_PX; i++) push_pixel(PIX_W'(i), 0);
        check_captured("b2b");
        checks++;
        if (rd_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL b2b_early: got rd_valid=%b required 0", rd_valid);
        end
        step();
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 8'h00) begin
            failures++;
            $display("[TB] FAIL b2b_first: got %b/%0h required 1/0", rd_valid, rd_data);
        end
        drain_frame("b2b", 100, 0, 1'b1);
    endtask

    task automatic test_random_gaps();
        start_frame(1'b0);
        for (int i = 0; i < FRAME_PX; i++) push_pixel(PIX_W'($urandom), 3);
        check_captured("gaps");
        drain_frame("gaps", 50, 0, 1'b0);
    endtask

    task automatic test_overflow();
        start_frame(1'b0);
        for (int i = 0; i < FRAME_PX; i++) push_pixel(PIX_W'($urandom), 1);
        check_captured("ovf");
        pixel_in       = 8'hAA;
        pixel_in_valid = 1'b1;
        expOverflow    = 1'b1;
        step();
        pixel_in_valid = 1'b0;
        checks++;
        if (overflow !== 1'b1) begin
            failures++;
            $display("[TB] FAIL ovf_set: got %b required 1", overflow);
        end
        drain_frame("ovf", 70, 30, 1'b0);
        pixel_in_valid = 1'b1;
        repeat (3) step();
        pixel_in_valid = 1'b0;
        checks++;
        if (overflow !== 1'b1 || px_count !== CNT_W'(FRAME_PX)) begin
            failures++;
            $display("[TB] FAIL ovf_idle: got ovf=%b px=%0d required 1 %0d", overflow, px_count, FRAME_PX);
        end
        start_frame(1'b0);
    endtask

    task automatic test_abort();
        start_frame(1'b0);
        for (int i = 0; i < 7; i++) push_pixel(PIX_W'($urandom), 1);
        check_captured("abort_partial");
        start_frame(1'b1);
        for (int i = 0; i < FRAME_PX; i++) push_pixel(PIX_W'(100 + i), 1);
        check_captured("abort");
        drain_frame("abort", 100, 0, 1'b1);
    endtask

    task automatic test_reset_mid_drain();
        start_frame(1'b0);
        for (int i = 0; i < FRAME_PX; i++) push_pixel(PIX_W'($urandom), 0);
        rd_ready = 1'b1;
        repeat (5) step();
        rd_ready = 1'b0;
        #2;
        rstN = 1'b0;
        #1;
        checks++;
        if (rd_valid !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0 || overflow !== 1'b0 ||
            rd_data !== '0 || px_count !== '0) begin
            failures++;
            $display("[TB] FAIL rst_drain: got rv=%b busy=%b done=%b ovf=%b data=%0h px=%0d required all 0",
                     rd_valid, busy, frame_done, overflow, rd_data, px_count);
        end
        expQ.delete();
        expCount = 0;
        @(negedge clk);
        rstN = 1'b1;
        pixel_in       = 8'h33;
        pixel_in_valid = 1'b1;
        repeat (4) step();
        pixel_in_valid = 1'b0;
        checks++;
        if (px_count !== '0 || busy !== 1'b0 || rd_valid !== 1'b0 || overflow !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rst_idle: got px=%0d busy=%b rv=%b ovf=%b required 0 0 0 0",
                     px_count, busy, rd_valid, overflow);
        end
    endtask

    task automatic test_all_ones();
        start_frame(1'b0);
        for (int i = 0; i < FRAME_PX; i++) push_pixel(8'hFF, 2);
        check_captured("ones");
        drain_frame("ones", 100, 0, 1'b1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish required finish before 500000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_back_to_back();
        test_random_gaps();
        test_overflow();
        test_abort();
        test_reset_mid_drain();
        test_all_ones();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
